line_mem_ctrl: RTL
==================

# line_mem_ctrl

Line-granular backing-memory controller sitting directly below the instruction cache and data cache. It accepts 128-bit line-fill reads from the I-side, and line reads or writes from the D-side. It arbitrates the two sides round-robin, serves one request at a time with a fixed programmable latency, and returns a one-cycle completion pulse. The I-side ports match the instruction cache's miss interface one-to-one: request, line address, returned line, ready pulse.

## Interface
- LATENCY, 4: cycles from grant edge to completion edge; must be ≥1.
- DEPTH, 1024: number of 128-bit lines in the internal store; power of two.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- reqI_mem  in  1  I-side read request, level; held high until read_ready_I is seen.
- reqAddrI_mem  in  26  I-side line address (byte address bits [29:4]).
- data_to_I  out  128  I-side returned line; valid while read_ready_I=1.
- read_ready_I  out  1  I-side completion pulse, one cycle.
- reqD_mem  in  1  D-side request, level; held until completion.
- reqD_write  in  1  D-side direction: 1=write, 0=read; sampled at grant.
- reqAddrD_mem  in  26  D-side line address.
- dataD_to_mem  in  128  D-side write line; sampled at grant.
- data_to_D  out  128  D-side returned line; valid while read_ready_D=1.
- read_ready_D  out  1  D-side read completion pulse, one cycle.
- written_ack_D  out  1  D-side write completion pulse, one cycle.

## Operation
- States:
  - IDLE: samples the requests.
  - BUSY: latency counter runs.
  - RESPOND: one-cycle completion pulse.
- IDLE transitions:
  - Any request high → latch side, address, direction and write data; load the counter with LATENCY-1; go to BUSY.
  - No request → stay in IDLE.
- BUSY transitions:
  - Counter ≠0 → decrement.
  - Counter =0 → perform the access; go to RESPOND.
- Access at completion:
  - Read: load the selected side's data output from store[idx].
  - Write: store[idx] ← latched data.
- RESPOND asserts exactly one of read_ready_I / read_ready_D / written_ack_D for one cycle. It then goes to IDLE unconditionally; requests are not sampled in RESPOND.
- Index: idx = address[log2(DEPTH)-1:0]. Higher address bits are ignored, so addresses alias modulo DEPTH.
- Arbitration: a last_grant bit; reset value selects I, so D wins the first tie.
  - Only one side requesting → that side is granted.
  - Both requesting → the side not granted last time wins.
  - last_grant updates on every grant.
- Requests are never aborted. A request that the requester withdraws mid-flight (for example on a cache flush) still completes and pulses its ready/ack. The requester ignores that pulse.
- data_to_I / data_to_D hold their last returned value until the next read for that side.
- Store contents are not cleared by reset and are zero at time 0.

## Timing
- Reset, while reset=0 at an edge:
  - state=IDLE, counter=0, last_grant=I.
  - data_to_I=0, data_to_D=0.
  - read_ready_I=0, read_ready_D=0, written_ack_D=0.
  - Store unchanged.
- Reset mid-operation: the in-flight request is dropped and a pending write is not performed. A requester still holding its request is re-granted after reset releases.
- Latency:
  - Request sampled high at grant edge E0.
  - Access performed at edge E0+LATENCY; the pulse is high from E0+LATENCY until E0+LATENCY+1.
  - State returns to IDLE at edge E0+LATENCY+1.
  - Earliest next grant is edge E0+LATENCY+2.
  - Back-to-back service period is LATENCY+2 cycles.
- The requester drops its request at the edge where it samples ready (E0+LATENCY+1). Because RESPOND does not sample, that stale request is never re-granted.
- Simultaneous requests arriving while BUSY wait, and are arbitrated at the next IDLE sample.

## Test plan
- Reset then I read, LATENCY=4: preload store[5]=128'hA5…A5; reqI_mem=1, reqAddrI_mem=5 at E0 → read_ready_I=1 exactly in the cycle after E4, data_to_I=A5…A5; no D pulses.
- D write then I read of same line: D write 128'h1234… to addr 9 at E0 → written_ack_D after E4. I read of addr 9 granted at E6 → read_ready_I after E10 with 128'h1234….
- Tie round-robin: both request from reset at E0 → D granted first (pulse after E4). I granted at E6 (pulse after E10). With both re-requesting, the next grant goes to D.
- Aliasing, DEPTH=1024: write line at addr 1024+3, then read addr 3 → the written data is returned.
- I request withdrawn after 2 cycles in BUSY → read_ready_I still pulses once at E0+LATENCY; the next IDLE sample grants nothing.
- reset=0 asserted in BUSY during a D write to addr 7 → all outputs 0 next cycle, store[7] unchanged, no ack pulse ever issued for that write.

Source files
------------

// File: rtl/line_mem_ctrl.sv
// Line-granular backing store below the I-cache and D-cache. Round-robin arbitration
// between the two sides, one request in flight, fixed latency, one-cycle completion pulse.
module line_mem_ctrl #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reqI_mem,
  input  logic [25:0]  reqAddrI_mem,
  output logic [127:0] data_to_I,
  output logic         read_ready_I,
  input  logic         reqD_mem,
  input  logic         reqD_write,
  input  logic [25:0]  reqAddrD_mem,
  input  logic [127:0] dataD_to_mem,
  output logic [127:0] data_to_D,
  output logic         read_ready_D,
  output logic         written_ack_D
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  // Side encoding used by side_q and last_grant_q: 0 = I, 1 = D.
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  logic [127:0]     store_q [DEPTH];

  logic [1:0]       state_q,        state_d;
  logic [CNT_W-1:0] cnt_q,          cnt_d;
  logic             last_grant_q,   last_grant_d;
  logic             side_q,         side_d;
  logic             wr_q,           wr_d;
  logic [IDX_W-1:0] idx_q,          idx_d;
  logic [127:0]     wdata_q,        wdata_d;
  logic [127:0]     data_to_I_q,    data_to_I_d;
  logic [127:0]     data_to_D_q,    data_to_D_d;
  logic             read_ready_I_q, read_ready_I_d;
  logic             read_ready_D_q, read_ready_D_d;
  logic             written_ack_q,  written_ack_d;
  logic             grant_d;
  logic             store_we;

  // Line addresses alias modulo DEPTH; the upper bits are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{reqAddrI_mem[25:IDX_W], reqAddrD_mem[25:IDX_W]};

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_grant_d   = last_grant_q;
    side_d         = side_q;
    wr_d           = wr_q;
    idx_d          = idx_q;
    wdata_d        = wdata_q;
    data_to_I_d    = data_to_I_q;
    data_to_D_d    = data_to_D_q;
    read_ready_I_d = 1'b0;
    read_ready_D_d = 1'b0;
    written_ack_d  = 1'b0;
    grant_d        = SIDE_I;
    store_we       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (reqI_mem || reqD_mem) begin
          // D wins when alone, or on a tie when I was granted last.
          grant_d      = reqD_mem && (!reqI_mem || (last_grant_q == SIDE_I));
          side_d       = grant_d;
          last_grant_d = grant_d;
          wr_d         = grant_d && reqD_write;
          idx_d        = grant_d ? reqAddrD_mem[IDX_W-1:0] : reqAddrI_mem[IDX_W-1:0];
          wdata_d      = dataD_to_mem;
          cnt_d        = CNT_LOAD;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_RESPOND;
          if (side_q == SIDE_D && wr_q) begin
            store_we      = 1'b1;
            written_ack_d = 1'b1;
          end else if (side_q == SIDE_D) begin
            data_to_D_d    = store_q[idx_q];
            read_ready_D_d = 1'b1;
          end else begin
            data_to_I_d    = store_q[idx_q];
            read_ready_I_d = 1'b1;
          end
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      last_grant_q   <= SIDE_I;
      data_to_I_q    <= '0;
      data_to_D_q    <= '0;
      read_ready_I_q <= 1'b0;
      read_ready_D_q <= 1'b0;
      written_ack_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_grant_q   <= last_grant_d;
      data_to_I_q    <= data_to_I_d;
      data_to_D_q    <= data_to_D_d;
      read_ready_I_q <= read_ready_I_d;
      read_ready_D_q <= read_ready_D_d;
      written_ack_q  <= written_ack_d;
    end
  end

  // Request payload is only consumed after a grant, so it needs no reset.
  always_ff @(posedge clk) begin
    side_q  <= side_d;
    wr_q    <= wr_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  // A reset landing on the access edge must suppress the pending write.
  always_ff @(posedge clk) begin
    if (store_we && reset) begin
      store_q[idx_q] <= wdata_q;
    end
  end

  assign data_to_I     = data_to_I_q;
  assign data_to_D     = data_to_D_q;
  assign read_ready_I  = read_ready_I_q;
  assign read_ready_D  = read_ready_D_q;
  assign written_ack_D = written_ack_q;

endmodule
